// File: rtl/frame_timing_ctrl.sv
// Frame timing sequencer: FVAL/LVAL/DVAL generation, frame/line strobes and
// frame-aligned pattern select (manual or auto-cycling).
//
// state       | meaning
// IDLE        | stopped, all timing outputs low, waits for enable
// FV_SETUP    | single fval-high cycle before the first line, sel updated
// LINE_ACTIVE | lval/dval high for DVAL_HIGH cycles
// LINE_BLANK  | lval low for H_BLANK cycles after each line
// FRAME_BLANK | fval low for V_BLANK cycles, enable sampled at the end
module frame_timing_ctrl #(
  parameter int unsigned DVAL_HIGH          = 640,
  parameter int unsigned ROW_COUNT          = 480,
  parameter int unsigned H_BLANK            = 32,
  parameter int unsigned V_BLANK            = 4,
  parameter int unsigned FRAMES_PER_PATTERN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        auto_mode,
  input  logic [2:0]  sel_in,
  output logic        fval,
  output logic        lval,
  output logic        dval,
  output logic        lval_negedge,
  output logic        fval_posedge,
  output logic [2:0]  sel,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    FV_SETUP,
    LINE_ACTIVE,
    LINE_BLANK,
    FRAME_BLANK
  } state_t;

  localparam logic [15:0] PIX_LAST = 16'(DVAL_HIGH - 1);
  localparam logic [15:0] ROW_LAST = 16'(ROW_COUNT - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);
  localparam logic [15:0] FPP      = 16'(FRAMES_PER_PATTERN);

  state_t      state_q, state_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] blank_q, blank_d;
  logic [15:0] line_q, line_d;
  logic [15:0] fpp_q, fpp_d;
  logic [2:0]  sel_d;

  function automatic logic [2:0] next_pattern(input logic [2:0] cur);
    case (cur)
      3'b000:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b011;
      3'b011:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic in_sequence(input logic [2:0] cur);
    return (cur == 3'b000) || (cur == 3'b001) || (cur == 3'b010) ||
           (cur == 3'b011) || (cur == 3'b111);
  endfunction

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    blank_d = blank_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FV_SETUP;
      end
      FV_SETUP: begin
        state_d = LINE_ACTIVE;
        pix_d   = PIX_LAST;
        line_d  = 16'd0;
      end
      LINE_ACTIVE: begin
        if (pix_q == 16'd0) begin
          state_d = LINE_BLANK;
          blank_d = HB_LAST;
        end else begin
          pix_d = pix_q - 16'd1;
        end
      end
      LINE_BLANK: begin
        if (blank_q != 16'd0) begin
          blank_d = blank_q - 16'd1;
        end else if (line_q == ROW_LAST) begin
          state_d = FRAME_BLANK;
          blank_d = VB_LAST;
        end else begin
          state_d = LINE_ACTIVE;
          pix_d   = PIX_LAST;
          line_d  = line_q + 16'd1;
        end
      end
      FRAME_BLANK: begin
        if (blank_q != 16'd0) begin
          blank_d = blank_q - 16'd1;
        end else begin
          state_d = enable ? FV_SETUP : IDLE;
          line_d  = 16'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern select only moves on the edge into FV_SETUP; a zero per-pattern
  // count marks "not currently auto-cycling" so the next auto frame restarts.
  always_comb begin
    sel_d = sel;
    fpp_d = fpp_q;
    if (state_d == FV_SETUP) begin
      if (!auto_mode) begin
        sel_d = sel_in;
        fpp_d = 16'd0;
      end else if ((fpp_q == 16'd0) || !in_sequence(sel)) begin
        sel_d = 3'b000;
        fpp_d = 16'd1;
      end else if (fpp_q >= FPP) begin
        sel_d = next_pattern(sel);
        fpp_d = 16'd1;
      end else begin
        fpp_d = fpp_q + 16'd1;
      end
    end else if (state_d == IDLE) begin
      fpp_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pix_q        <= 16'd0;
      blank_q      <= 16'd0;
      line_q       <= 16'd0;
      fpp_q        <= 16'd0;
      sel          <= 3'b000;
      fval         <= 1'b0;
      lval         <= 1'b0;
      dval         <= 1'b0;
      lval_negedge <= 1'b0;
      fval_posedge <= 1'b0;
      frame_count  <= 16'd0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      blank_q      <= blank_d;
      line_q       <= line_d;
      fpp_q        <= fpp_d;
      sel          <= sel_d;
      fval         <= (state_d == FV_SETUP) || (state_d == LINE_ACTIVE) ||
                      (state_d == LINE_BLANK);
      lval         <= (state_d == LINE_ACTIVE);
      dval         <= (state_d == LINE_ACTIVE);
      lval_negedge <= (state_d == LINE_BLANK) && (state_q == LINE_ACTIVE);
      fval_posedge <= (state_d == FV_SETUP);
      busy         <= (state_d != IDLE);
      if ((state_d == FRAME_BLANK) && (state_q != FRAME_BLANK))
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// Directed bench for frame_timing_ctrl with small frame geometry
// (8 pixels x 4 lines, 2 h-blank, 3 v-blank: 44-cycle frame period).
module tb_frame_timing_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        auto_mode;
  logic [2:0]  sel_in;
  logic        fval, lval, dval, lval_negedge, fval_posedge, busy;
  logic [2:0]  sel;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  // per-frame statistics filled by measure_frame
  int period, lval_cyc, pulses, bad_len, neg_cnt, neg_bad;
  int fval_low, dval_nofval, dval_mis, first_dval, sel_chg;

  frame_timing_ctrl #(
    .DVAL_HIGH(8), .ROW_COUNT(4), .H_BLANK(2), .V_BLANK(3),
    .FRAMES_PER_PATTERN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .auto_mode(auto_mode),
    .sel_in(sel_in), .fval(fval), .lval(lval), .dval(dval),
    .lval_negedge(lval_negedge), .fval_posedge(fval_posedge), .sel(sel),
    .frame_count(frame_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_start(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fval_posedge) begin
        ok = 1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Starts on a fval_posedge cycle, ends on the next one (or after a bound).
  task automatic measure_frame(input int chg_at, input logic [2:0] chg_val);
    logic prev_lval;
    logic [2:0] prev_sel;
    int run;
    period = 0; lval_cyc = 0; pulses = 0; bad_len = 0; neg_cnt = 0; neg_bad = 0;
    fval_low = 0; dval_nofval = 0; dval_mis = 0; first_dval = -1; sel_chg = 0;
    run = 0;
    prev_lval = lval;
    prev_sel = sel;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == chg_at) sel_in = chg_val;
      if (fval_posedge) begin
        period = i;
        break;
      end
      if (lval) begin
        lval_cyc++;
        run++;
        if (!prev_lval) pulses++;
      end
      if (!lval && prev_lval) begin
        if (run != 8) bad_len++;
        run = 0;
        if (!lval_negedge) neg_bad++;
      end
      if (lval_negedge) begin
        neg_cnt++;
        if (!(prev_lval && !lval)) neg_bad++;
      end
      if (!fval) begin
        fval_low++;
        if (dval) dval_nofval++;
      end
      if (dval !== lval) dval_mis++;
      if (dval && first_dval < 0) first_dval = i;
      if (sel !== prev_sel) sel_chg++;
      prev_lval = lval;
      prev_sel = sel;
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_period"}, 32'(period), 32'd44);
    check({tag, "_lval_cycles"}, 32'(lval_cyc), 32'd32);
    check({tag, "_lval_pulses"}, 32'(pulses), 32'd4);
    check({tag, "_lval_len_bad"}, 32'(bad_len), 32'd0);
    check({tag, "_negedge_cnt"}, 32'(neg_cnt), 32'd4);
    check({tag, "_negedge_align"}, 32'(neg_bad), 32'd0);
    check({tag, "_fval_low"}, 32'(fval_low), 32'd3);
    check({tag, "_dval_no_fval"}, 32'(dval_nofval), 32'd0);
    check({tag, "_dval_vs_lval"}, 32'(dval_mis), 32'd0);
    check({tag, "_first_dval"}, 32'(first_dval), 32'd1);
    check({tag, "_sel_stable"}, 32'(sel_chg), 32'd0);
  endtask

  logic [2:0] auto_seq [11] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010,
                                3'b011, 3'b011, 3'b111, 3'b111, 3'b000};

  initial begin
    int idle_at;
    rst_n = 1'b0;
    enable = 1'b0;
    auto_mode = 1'b0;
    sel_in = 3'b011;

    tick(); tick(); tick();
    check("reset_flags", 32'({fval, lval, dval, lval_negedge, fval_posedge, busy}), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_busy", 32'(busy), 32'd0);

    // manual select, change of sel_in mid-frame
    enable = 1'b1;
    wait_frame_start("f1_start");
    check("f1_sel", 32'(sel), 32'h3);
    check("f1_fc", 32'(frame_count), 32'd0);
    check("f1_fval", 32'(fval), 32'd1);
    check("f1_lval", 32'(lval), 32'd0);
    measure_frame(15, 3'b001);
    check_frame("f1");
    check("f2_sel", 32'(sel), 32'h1);
    check("f2_fc", 32'(frame_count), 32'd1);

    // auto mode picked up at the next frame start
    auto_mode = 1'b1;
    measure_frame(-1, 3'b000);
    check_frame("f2");
    check("f3_fc", 32'(frame_count), 32'd2);

    for (int k = 0; k < 11; k++) begin
      check($sformatf("auto_sel_%0d", k), 32'(sel), 32'(auto_seq[k]));
      if (k < 10) begin
        measure_frame(-1, 3'b000);
        check($sformatf("auto_period_%0d", k), 32'(period), 32'd44);
        check($sformatf("auto_sel_stable_%0d", k), 32'(sel_chg), 32'd0);
      end
    end
    check("auto_end_fc", 32'(frame_count), 32'd12);

    // drop enable during line 2: frame must complete, then idle
    idle_at = 0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t == 14) enable = 1'b0;
      if (!busy) begin
        idle_at = t;
        break;
      end
    end
    check("drop_idle_at", 32'(idle_at), 32'd44);
    check("drop_fval", 32'(fval), 32'd0);
    check("drop_fc", 32'(frame_count), 32'd13);
    for (int t = 0; t < 20; t++) tick();
    check("drop_stay_idle", 32'({busy, fval, fval_posedge}), 32'd0);
    check("drop_fc_hold", 32'(frame_count), 32'd13);

    // asynchronous reset in LINE_ACTIVE
    auto_mode = 1'b0;
    sel_in = 3'b011;
    enable = 1'b1;
    wait_frame_start("r_pre_start");
    check("r_pre_sel", 32'(sel), 32'h3);
    tick(); tick(); tick();
    check("r_pre_lval", 32'(lval), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_async_flags", 32'({fval, lval, dval, lval_negedge, fval_posedge, busy}), 32'd0);
    check("r_async_sel", 32'(sel), 32'd0);
    check("r_async_fc", 32'(frame_count), 32'd0);
    tick(); tick();
    auto_mode = 1'b1;
    rst_n = 1'b1;
    wait_frame_start("r_post_start");
    check("r_post_sel0", 32'(sel), 32'd0);
    check("r_post_fc", 32'(frame_count), 32'd0);
    measure_frame(-1, 3'b000);
    check_frame("r1");
    check("r_post_sel1", 32'(sel), 32'd0);
    measure_frame(-1, 3'b000);
    check("r2_period", 32'(period), 32'd44);
    check("r_post_sel2", 32'(sel), 32'h1);
    check("r_post_fc2", 32'(frame_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
